// File: rtl/axi_burst_initiator_pkg.sv
// Shared types and helpers for the single-burst AXI4 initiator.
package axi_burst_init_pkg;

    localparam int unsigned Bytes4k = 4096;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] BurstIncr  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_RSP
    } state_e;

    // Debug view of the controller: FSM state and beat counter.
    typedef struct packed {
        state_e     state;
        logic [7:0] cnt;
    } dbg_t;

    // Default AXI4 channel layout for the default parameter set.
    // Instantiating scopes normally pass their own req_t/rsp_t.
    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefDataWidth = 64;
    localparam int unsigned DefIdWidth   = 4;
    localparam int unsigned DefUserWidth = 1;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [DefAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [5:0]              atop;
        logic [DefUserWidth-1:0] user;
    } def_aw_chan_t;

    typedef struct packed {
        logic [DefDataWidth-1:0]   data;
        logic [DefDataWidth/8-1:0] strb;
        logic                      last;
        logic [DefUserWidth-1:0]   user;
    } def_w_chan_t;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [1:0]              resp;
        logic [DefUserWidth-1:0] user;
    } def_b_chan_t;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [DefAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [DefUserWidth-1:0] user;
    } def_ar_chan_t;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [DefDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [DefUserWidth-1:0] user;
    } def_r_chan_t;

    typedef struct packed {
        def_aw_chan_t aw;
        logic         aw_valid;
        def_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        def_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } def_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        def_b_chan_t b;
        logic        r_valid;
        def_r_chan_t r;
    } def_rsp_t;

    // Unsigned max of two AXI responses (higher code = worse outcome).
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // True when a burst starting at 'offset' within its 4 KiB page runs past the page end.
    function automatic logic crosses_4k(input logic [11:0] offset, input logic [7:0] len,
                                        input logic [2:0] size);
        logic [31:0] bytes;
        bytes = (32'(len) + 32'd1) << size;
        return (32'(offset) + bytes) > Bytes4k;
    endfunction

endpackage

// File: rtl/axi_burst_initiator.sv
// Single-burst AXI4 initiator: one INCR read or write burst per command,
// with pass-through write and read beat streams and a completion port.
//
// Handshakes: every valid/ready pair transfers on a rising edge where both
// are high; a valid, once raised, holds its payload until ready is seen.
module axi_burst_initiator
    import axi_burst_init_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1,
    parameter type         req_t     = def_req_t,
    parameter type         rsp_t     = def_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_write_i,
    input  logic [AddrWidth-1:0]   cmd_addr_i,
    input  logic [7:0]             cmd_len_i,
    input  logic [2:0]             cmd_size_i,
    input  logic [IdWidth-1:0]     cmd_id_i,
    input  logic                   wdata_valid_i,
    output logic                   wdata_ready_o,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    output logic                   rdata_valid_o,
    input  logic                   rdata_ready_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   rdata_last_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [1:0]             rsp_resp_o,
    output logic                   rsp_proto_err_o,
    output req_t                   axi_req_o,
    input  rsp_t                   axi_rsp_i,
    output dbg_t                   dbg_o
);

    localparam logic [2:0] MaxSize = 3'($clog2(DataWidth / 8));

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [7:0]           len_q;
    logic [2:0]           size_q;
    logic [IdWidth-1:0]   id_q;
    logic [7:0]           cnt_q;
    logic [1:0]           resp_q;
    logic                 perr_q;

    logic cmd_hs, w_hs, r_hs, b_hs, rsp_hs, r_end;
    logic cmd_illegal, cnt_at_len;
    logic unused_rsp_user;

    assign unused_rsp_user = ^{axi_rsp_i.b.user, axi_rsp_i.r.user};

    assign rsp_resp_o      = resp_q;
    assign rsp_proto_err_o = perr_q;
    assign dbg_o.state     = state_q;
    assign dbg_o.cnt       = cnt_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state, handshake decode and all channel outputs.
    always_comb begin
        state_d       = state_q;
        axi_req_o     = '0;
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        rdata_valid_o = 1'b0;
        rdata_o       = axi_rsp_i.r.data;
        rdata_last_o  = 1'b0;
        rsp_valid_o   = 1'b0;
        cmd_hs        = 1'b0;
        w_hs          = 1'b0;
        r_hs          = 1'b0;
        b_hs          = 1'b0;
        rsp_hs        = 1'b0;
        r_end         = 1'b0;
        cnt_at_len    = (cnt_q == len_q);
        cmd_illegal   = (cmd_size_i > MaxSize) ||
                        crosses_4k(12'(cmd_addr_i), cmd_len_i, cmd_size_i);

        // Payloads come from the registered command; the valids gate them.
        axi_req_o.aw.id    = id_q;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.len   = len_q;
        axi_req_o.aw.size  = size_q;
        axi_req_o.aw.burst = BurstIncr;
        axi_req_o.aw.user  = {UserWidth{1'b0}};
        axi_req_o.ar.id    = id_q;
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.len   = len_q;
        axi_req_o.ar.size  = size_q;
        axi_req_o.ar.burst = BurstIncr;
        axi_req_o.ar.user  = {UserWidth{1'b0}};
        axi_req_o.w.data   = wdata_i;
        axi_req_o.w.strb   = wstrb_i;
        axi_req_o.w.last   = cnt_at_len;
        axi_req_o.w.user   = {UserWidth{1'b0}};

        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = !rst_i;
                cmd_hs      = cmd_valid_i && !rst_i;
                if (cmd_hs) begin
                    if (cmd_illegal)      state_d = ST_RSP;
                    else if (cmd_write_i) state_d = ST_AW;
                    else                  state_d = ST_AR;
                end
            end
            ST_AW: begin
                axi_req_o.aw_valid = 1'b1;
                if (axi_rsp_i.aw_ready) state_d = ST_W;
            end
            ST_W: begin
                axi_req_o.w_valid = wdata_valid_i;
                wdata_ready_o     = axi_rsp_i.w_ready;
                w_hs              = wdata_valid_i && axi_rsp_i.w_ready;
                if (w_hs && cnt_at_len) state_d = ST_B;
            end
            ST_B: begin
                axi_req_o.b_ready = 1'b1;
                b_hs              = axi_rsp_i.b_valid;
                if (b_hs) state_d = ST_RSP;
            end
            ST_AR: begin
                axi_req_o.ar_valid = 1'b1;
                if (axi_rsp_i.ar_ready) state_d = ST_R;
            end
            ST_R: begin
                rdata_valid_o     = axi_rsp_i.r_valid;
                axi_req_o.r_ready = rdata_ready_i;
                rdata_last_o      = axi_rsp_i.r.last;
                r_hs              = axi_rsp_i.r_valid && rdata_ready_i;
                // Stop on the subordinate's last or on our own count, whichever first.
                r_end             = r_hs && (axi_rsp_i.r.last || cnt_at_len);
                if (r_end) state_d = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid_o = 1'b1;
                rsp_hs      = rsp_ready_i;
                if (rsp_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command registers, beat counter and accumulated completion status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            len_q  <= '0;
            size_q <= '0;
            id_q   <= '0;
            cnt_q  <= '0;
            resp_q <= RespOkay;
            perr_q <= 1'b0;
        end else begin
            if (cmd_hs) begin
                addr_q <= cmd_addr_i;
                len_q  <= cmd_len_i;
                size_q <= cmd_size_i;
                id_q   <= cmd_id_i;
                if (cmd_illegal) begin
                    resp_q <= RespSlverr;
                    perr_q <= 1'b0;
                end
            end
            if (w_hs) cnt_q <= cnt_at_len ? 8'd0 : 8'(cnt_q + 8'd1);
            if (b_hs) begin
                resp_q <= axi_rsp_i.b.resp;
                perr_q <= (axi_rsp_i.b.id != id_q);
            end
            if (r_hs) begin
                resp_q <= resp_max(resp_q, axi_rsp_i.r.resp);
                if ((axi_rsp_i.r.id != id_q) || (axi_rsp_i.r.last != cnt_at_len)) perr_q <= 1'b1;
                cnt_q <= r_end ? 8'd0 : 8'(cnt_q + 8'd1);
            end
            if (rsp_hs) begin
                resp_q <= RespOkay;
                perr_q <= 1'b0;
            end
        end
    end

endmodule
